// File: rtl/restoring_divider8_if.sv
// Handshake and result bundle for restoring_divider8.
// The master drives the operands and start; the slave returns status and results.
interface restoring_divider8_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [3:0] rem;
  logic       dbz;
  logic       check_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quot, rem, dbz, check_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quot, rem, dbz, check_err
  );
endinterface

// File: rtl/restoring_divider8.sv
// 8-bit by 4-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_SELFCHECK_EN to add a quot*divisor+rem == dividend check on completion.
module restoring_divider8 (
  input logic                 clk,
  input logic                 rst,
  restoring_divider8_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [4:0] pr_q;
  logic [7:0] wq_q;
  logic [2:0] cnt_q;
  logic [7:0] quot_q;
  logic [3:0] rem_q;
  logic       dbz_q;

  logic       accept;
  logic       calc_last;
  logic       busy;
  logic       done;
  logic [4:0] pr_shift;
  logic [4:0] pr_step;
  logic       q_bit;
  logic [7:0] quot_step;

  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign calc_last = (state_q == StCalc) && (cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = (bus.divisor == 4'd0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 3'd7) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StCalc:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Remainder stays below the divisor, so pr_q[4] is always 0 before the shift.
  always_comb begin
    pr_shift  = {pr_q[3:0], dvd_q[3'd7 - cnt_q]};
    q_bit     = (pr_shift >= {1'b0, dvs_q});
    pr_step   = q_bit ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
    quot_step = {wq_q[6:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      pr_q   <= '0;
      wq_q   <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      dvd_q <= bus.dividend;
      dvs_q <= bus.divisor;
      pr_q  <= '0;
      wq_q  <= '0;
      cnt_q <= '0;
      if (bus.divisor == 4'd0) begin
        quot_q <= 8'hFF;
        rem_q  <= bus.dividend[3:0];
        dbz_q  <= 1'b1;
      end
    end else if (state_q == StCalc) begin
      pr_q <= pr_step;
      wq_q <= quot_step;
      if (calc_last) begin
        quot_q <= quot_step;
        rem_q  <= pr_step[3:0];
        dbz_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

`ifdef DIV_SELFCHECK_EN
  logic [11:0] chk_sum;
  logic        err_q;

  assign chk_sum = ({4'd0, quot_step} * {8'd0, dvs_q}) + {8'd0, pr_step[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (bus.divisor == 4'd0)) begin
      err_q <= 1'b0;
    end else if (calc_last) begin
      err_q <= (chk_sum != {4'd0, dvd_q});
    end
  end

  assign bus.check_err = err_q;
`else
  assign bus.check_err = 1'b0;
`endif

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: doc/restoring_divider8.md
RESTORING_DIVIDER8 -- requirements
Module: restoring_divider8

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (8-bit dividend, 4-bit divisor).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 dividend  input  8  unsigned dividend; captured on accepted start.
REQ-006 divisor  input  4  unsigned divisor; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quot  output  8  unsigned quotient; held until next accepted start.
REQ-010 rem  output  4  unsigned remainder; held until next accepted start.
REQ-011 dbz  output  1  divide-by-zero flag for the last operation; held like quot.
REQ-012 check_err  output  1  self-check mismatch flag; see Configuration.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: start=1 SHALL latch dividend/divisor, clear the partial remainder and the iteration counter, and go to CALC, or go to DONE if divisor=0.
REQ-015 CALC SHALL perform one restoring step per cycle: pr = {pr[3:0], next dividend bit MSB-first}; if pr >= divisor then pr = pr - divisor and the quotient bit is 1, else the quotient bit is 0.
REQ-016 The partial remainder SHALL be 5 bits wide; the compare and subtract SHALL use the zero-extended divisor.
REQ-017 A 3-bit counter SHALL sequence exactly 8 CALC cycles, then go to DONE; the counter SHALL not wrap into a ninth step.
REQ-018 DONE SHALL last exactly one cycle with done=1, then go to IDLE unless start=1, which SHALL be accepted as in IDLE.
REQ-019 Latency: start accepted at edge N means done=1 in the cycle after edge N+9 for a nonzero divisor, and in the cycle after edge N+1 for divisor=0.
REQ-020 busy SHALL be 1 exactly in CALC.
REQ-021 start during CALC SHALL be ignored with no effect on the operation or the operands.
REQ-022 quot/rem/dbz SHALL update only on entry to DONE.
REQ-023 Divisor=0 SHALL give quot=8'hFF, rem=dividend[3:0], dbz=1.
REQ-024 Any nonzero divisor SHALL give dbz=0 and exact results: dividend = quot*divisor + rem, rem < divisor.
REQ-025 Input changes after an accepted start SHALL not affect the result.

Reset
REQ-026 rst=1 SHALL force IDLE and set busy, done, quot, rem, dbz and check_err to 0 at the next edge, including mid-CALC or in DONE.
REQ-027 rst SHALL take priority over start in the same cycle; an aborted operation SHALL produce no done pulse.

Configuration
REQ-028 Macro DIV_SELFCHECK_EN SHALL control the self-check.
REQ-029 With DIV_SELFCHECK_EN defined: on entry to DONE with dbz=0, the block SHALL compute quot*divisor+rem (12-bit) combinationally and compare it to the latched dividend; on mismatch it SHALL set check_err=1, held like quot.
REQ-030 Without DIV_SELFCHECK_EN: check_err SHALL be tied to 0 and no check logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-031 dividend=200, divisor=7, start pulse -> busy for 8 cycles; done at cycle 9; quot=28, rem=4, dbz=0, check_err=0.
REQ-032 dividend=255, divisor=1 -> quot=255, rem=0; dividend=0, divisor=5 -> quot=0, rem=0.
REQ-033 dividend=8'h3C, divisor=0 -> done one cycle after start; quot=8'hFF, rem=4'hC, dbz=1, busy never high.
REQ-034 Start 200/7, re-pulse start with 9/3 during cycle 4 of CALC -> result still 28 r4; the second start is ignored.
REQ-035 Start 100/9, assert rst in CALC cycle 5 -> IDLE next edge, all outputs 0, no done pulse; a following start 100/9 -> quot=11, rem=1.
REQ-036 Back-to-back: start held high through DONE of 50/6 -> quot=8, rem=2, then a new operation begins immediately with no IDLE cycle.
